// File: rtl/ram_port_arbiter.sv
// Valid/ready front-end for a 1RO/1RW core RAM: port A serves instruction fetch,
// port B is shared round-robin between the data (d_*) and debug/loader (g_*) requesters.
module ram_port_arbiter #(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS/8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // fetch requester
  input  logic                   i_req_valid,
  output logic                   i_req_ready,
  input  logic [p_ADDR_BITS-1:0] i_req_addr,
  output logic                   i_resp_valid,
  input  logic                   i_resp_ready,
  output logic [p_DATA_BITS-1:0] i_resp_data,
  // data requester
  input  logic                   d_req_valid,
  output logic                   d_req_ready,
  input  logic [p_ADDR_BITS-1:0] d_req_addr,
  input  logic                   d_req_wen,
  input  logic [p_STRB_BITS-1:0] d_req_strb,
  input  logic [p_DATA_BITS-1:0] d_req_wdata,
  output logic                   d_resp_valid,
  input  logic                   d_resp_ready,
  output logic [p_DATA_BITS-1:0] d_resp_data,
  // debug/loader requester
  input  logic                   g_req_valid,
  output logic                   g_req_ready,
  input  logic [p_ADDR_BITS-1:0] g_req_addr,
  input  logic                   g_req_wen,
  input  logic [p_STRB_BITS-1:0] g_req_strb,
  input  logic [p_DATA_BITS-1:0] g_req_wdata,
  output logic                   g_resp_valid,
  input  logic                   g_resp_ready,
  output logic [p_DATA_BITS-1:0] g_resp_data,
  // RAM port A
  output logic [p_ADDR_BITS-1:0] addra,
  output logic                   rena,
  input  logic [p_DATA_BITS-1:0] qa,
  // RAM port B
  output logic [p_ADDR_BITS-1:0] addrb,
  output logic                   renb,
  output logic                   wenb,
  output logic [p_STRB_BITS-1:0] webb,
  output logic [p_DATA_BITS-1:0] datab,
  input  logic [p_DATA_BITS-1:0] qb
);

  localparam logic [0:0] A_IDLE   = 1'b0;
  localparam logic [0:0] A_PEND   = 1'b1;
  localparam logic [1:0] B_IDLE   = 2'd0;
  localparam logic [1:0] B_PEND_D = 2'd1;
  localparam logic [1:0] B_PEND_G = 2'd2;

  typedef struct packed {
    logic [p_ADDR_BITS-1:0] addr;
    logic                   wen;
    logic [p_STRB_BITS-1:0] strb;
    logic [p_DATA_BITS-1:0] wdata;
  } breq_t;

  function automatic logic [p_ADDR_BITS-1:0] word_idx(input logic [p_ADDR_BITS-1:0] a);
    return {2'b00, a[p_ADDR_BITS-1:2]};
  endfunction

  // ---------------- port A ----------------
  logic [0:0] st_a;
  logic       a_hs;

  assign i_resp_valid = (st_a == A_PEND);
  assign a_hs         = i_resp_valid & i_resp_ready;
  assign i_req_ready  = rst_n & ((st_a == A_IDLE) | a_hs);
  assign rena         = i_req_valid & i_req_ready;
  assign addra        = word_idx(i_req_addr);
  // RAM output holds while rena=0, so a stalled response needs no capture register
  assign i_resp_data  = qa;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     st_a <= A_IDLE;
    else if (rena)  st_a <= A_PEND;
    else if (a_hs)  st_a <= A_IDLE;
  end

  // ---------------- port B ----------------
  logic [1:0] st_b;
  logic       rr;     // last grant: 0=d, 1=g
  logic       wr_b;   // outstanding port-B access was a write
  logic       b_free, gnt_d, gnt_g;
  breq_t      d_req, g_req, sel;

  assign d_req = '{addr: d_req_addr, wen: d_req_wen, strb: d_req_strb, wdata: d_req_wdata};
  assign g_req = '{addr: g_req_addr, wen: g_req_wen, strb: g_req_strb, wdata: g_req_wdata};

  assign d_resp_valid = (st_b == B_PEND_D);
  assign g_resp_valid = (st_b == B_PEND_G);
  assign b_free = rst_n & ((st_b == B_IDLE) |
                           (d_resp_valid & d_resp_ready) |
                           (g_resp_valid & g_resp_ready));

  // on a tie the requester that did not win last time goes first
  assign gnt_d = b_free & d_req_valid & (~g_req_valid | rr);
  assign gnt_g = b_free & g_req_valid & (~d_req_valid | ~rr);
  assign d_req_ready = gnt_d;
  assign g_req_ready = gnt_g;

  assign sel   = gnt_g ? g_req : d_req;
  assign addrb = word_idx(sel.addr);
  assign webb  = sel.strb;
  assign datab = sel.wdata;
  assign renb  = (gnt_d | gnt_g) & ~sel.wen;
  assign wenb  = (gnt_d | gnt_g) &  sel.wen;

  assign d_resp_data = wr_b ? '0 : qb;
  assign g_resp_data = wr_b ? '0 : qb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_b <= B_IDLE;
      rr   <= 1'b1;
      wr_b <= 1'b0;
    end else if (gnt_d) begin
      st_b <= B_PEND_D;
      rr   <= 1'b0;
      wr_b <= sel.wen;
    end else if (gnt_g) begin
      st_b <= B_PEND_G;
      rr   <= 1'b1;
      wr_b <= sel.wen;
    end else if (b_free) begin
      st_b <= B_IDLE;
    end
  end

  // byte-offset bits are intentionally ignored
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_req_addr[1:0], sel.addr[1:0]};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM + queue-based response model checked
// every cycle, plus directed scenarios with hand-computed literal results.
module tb_ram_port_arbiter;
  localparam int AW = 32, DW = 32, SW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req_valid = 0, i_req_ready, i_resp_valid, i_resp_ready = 1;
  logic [AW-1:0] i_req_addr = '0;
  logic [DW-1:0] i_resp_data;
  logic d_req_valid = 0, d_req_ready, d_req_wen = 0, d_resp_valid, d_resp_ready = 1;
  logic [AW-1:0] d_req_addr = '0;
  logic [SW-1:0] d_req_strb = '0;
  logic [DW-1:0] d_req_wdata = '0, d_resp_data;
  logic g_req_valid = 0, g_req_ready, g_req_wen = 0, g_resp_valid, g_resp_ready = 1;
  logic [AW-1:0] g_req_addr = '0;
  logic [SW-1:0] g_req_strb = '0;
  logic [DW-1:0] g_req_wdata = '0, g_resp_data;
  logic [AW-1:0] addra, addrb;
  logic rena, renb, wenb;
  logic [SW-1:0] webb;
  logic [DW-1:0] datab, qa, qb;

  ram_port_arbiter #(.p_ADDR_BITS(AW), .p_DATA_BITS(DW), .p_STRB_BITS(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_strb(d_req_strb), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data),
    .g_req_valid(g_req_valid), .g_req_ready(g_req_ready), .g_req_addr(g_req_addr),
    .g_req_wen(g_req_wen), .g_req_strb(g_req_strb), .g_req_wdata(g_req_wdata),
    .g_resp_valid(g_resp_valid), .g_resp_ready(g_resp_ready), .g_resp_data(g_resp_data),
    .addra(addra), .rena(rena), .qa(qa),
    .addrb(addrb), .renb(renb), .wenb(wenb), .webb(webb), .datab(datab), .qb(qb)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 8) ? 32'h1122_3344 : 32'h1000_0000 + 32'(i);
  endfunction

  // behavioural dual-port RAM: registered reads, byte-strobed writes, A reads old data
  logic [31:0] ram [0:255];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else begin
      if (rena) qa <= ram[addra[7:0]];
      if (renb) qb <= ram[addrb[7:0]];
      if (wenb)
        for (int k = 0; k < 4; k++)
          if (webb[k]) ram[addrb[7:0]][k*8 +: 8] <= datab[k*8 +: 8];
    end
  end

  int nvec = 0, nerr = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model state: expected response queues, reference memory, tie-break pointer, logs
  logic [31:0] mem_m [0:255];
  logic [31:0] aq[$], dq[$], gq[$];
  logic [31:0] alog[$], dlog[$], glog[$], grnt[$];
  bit rr_m;

  initial begin
    bit d_own, g_own, free, ed, eg, wen;
    logic [31:0] adr, wd, idx;
    logic [3:0] st;
    for (int i = 0; i < 256; i++) mem_m[i] = init_val(i);
    rr_m = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_i_req_ready", i_req_ready, 0);
        check("rst_d_req_ready", d_req_ready, 0);
        check("rst_g_req_ready", g_req_ready, 0);
        check("rst_enables", {rena, renb, wenb}, 0);
        check("rst_resp_valid", {i_resp_valid, d_resp_valid, g_resp_valid}, 0);
        aq.delete(); dq.delete(); gq.delete();
        rr_m = 1'b1;
      end else begin
        // port A
        check("i_resp_valid", i_resp_valid, aq.size() != 0);
        check("i_req_ready", i_req_ready, (aq.size() == 0) || i_resp_ready);
        ed = i_req_valid && ((aq.size() == 0) || i_resp_ready);
        check("rena", rena, ed);
        if (i_resp_valid && i_resp_ready) begin
          if (aq.size() == 0) check("i_resp_unexpected", 1, 0);
          else begin check("i_resp_data", i_resp_data, aq[0]); alog.push_back(i_resp_data); void'(aq.pop_front()); end
        end
        if (ed) begin
          check("addra", addra, {2'b00, i_req_addr[31:2]});
          aq.push_back(mem_m[i_req_addr[9:2]]);
        end
        // port B
        d_own = dq.size() != 0;
        g_own = gq.size() != 0;
        check("d_resp_valid", d_resp_valid, d_own);
        check("g_resp_valid", g_resp_valid, g_own);
        free = (!d_own && !g_own) || (d_own && d_resp_ready) || (g_own && g_resp_ready);
        ed = free && d_req_valid && (!g_req_valid || rr_m);
        eg = free && g_req_valid && (!d_req_valid || !rr_m);
        check("d_req_ready", d_req_ready, ed);
        check("g_req_ready", g_req_ready, eg);
        if (d_resp_valid && d_resp_ready && d_own) begin
          check("d_resp_data", d_resp_data, dq[0]); dlog.push_back(d_resp_data); void'(dq.pop_front());
        end
        if (g_resp_valid && g_resp_ready && g_own) begin
          check("g_resp_data", g_resp_data, gq[0]); glog.push_back(g_resp_data); void'(gq.pop_front());
        end
        if (ed || eg) begin
          adr = eg ? g_req_addr : d_req_addr;
          wen = eg ? g_req_wen : d_req_wen;
          st  = eg ? g_req_strb : d_req_strb;
          wd  = eg ? g_req_wdata : d_req_wdata;
          idx = {24'b0, adr[9:2]};
          check("addrb", addrb, {2'b00, adr[31:2]});
          check("renb", renb, !wen);
          check("wenb", wenb, wen);
          if (wen) begin
            check("webb", webb, st);
            check("datab", datab, wd);
            for (int k = 0; k < 4; k++) if (st[k]) mem_m[idx][k*8 +: 8] = wd[k*8 +: 8];
          end
          if (eg) gq.push_back(wen ? 32'h0 : mem_m[idx]);
          else    dq.push_back(wen ? 32'h0 : mem_m[idx]);
          grnt.push_back(eg ? 32'd1 : 32'd0);
          rr_m = eg;
        end else begin
          check("renb_idle", renb, 0);
          check("wenb_idle", wenb, 0);
        end
      end
    end
  end

  task automatic a_fetch(input logic [31:0] a);
    int n = 0;
    i_req_valid = 1'b1; i_req_addr = a;
    @(negedge clk);
    while (!i_req_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("a_fetch_timeout", 1, 0);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic b_req(input bit use_g, input bit wen, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] w);
    int n = 0;
    if (use_g) begin g_req_valid = 1; g_req_wen = wen; g_req_addr = a; g_req_strb = s; g_req_wdata = w; end
    else       begin d_req_valid = 1; d_req_wen = wen; d_req_addr = a; d_req_strb = s; d_req_wdata = w; end
    @(negedge clk);
    while (!(use_g ? g_req_ready : d_req_ready) && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("b_req_timeout", 1, 0);
    @(posedge clk); #1;
    if (use_g) begin g_req_valid = 0; g_req_wen = 0; end
    else       begin d_req_valid = 0; d_req_wen = 0; end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: run did not complete, vectors %0d", nvec);
    $fatal(1);
  end

  initial begin
    int na, nd, ng, n;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;

    // first tie after reset goes to d, then g
    n = grnt.size(); nd = dlog.size(); ng = glog.size();
    d_req_valid = 1; d_req_addr = 32'h30; g_req_valid = 1; g_req_addr = 32'h34;
    @(negedge clk);
    check("tie0_d_ready", d_req_ready, 1);
    check("tie0_g_ready", g_req_ready, 0);
    @(posedge clk); #1 d_req_valid = 0;
    @(posedge clk); #1 g_req_valid = 0;
    repeat (2) @(posedge clk); #1;
    check("tie0_grants", grnt.size() - n, 2);
    check("tie0_first", grnt[n], 0);
    check("tie0_second", grnt[n+1], 1);
    check("tie0_d_data", dlog[nd], 32'h1000_000C);
    check("tie0_g_data", glog[ng], 32'h1000_000D);

    // back-to-back fetches
    na = alog.size();
    a_fetch(32'h0); a_fetch(32'h4); a_fetch(32'h8);
    repeat (2) @(posedge clk); #1;
    check("b2b_count", alog.size() - na, 3);
    check("b2b_w0", alog[na], 32'h1000_0000);
    check("b2b_w1", alog[na+1], 32'h1000_0001);
    check("b2b_w2", alog[na+2], 32'h1000_0002);

    // stalled fetch response; port B keeps working meanwhile
    na = alog.size(); nd = dlog.size();
    i_resp_ready = 0;
    a_fetch(32'h10);
    i_req_valid = 1; i_req_addr = 32'h18;
    b_req(0, 0, 32'h24, 4'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("stall_req_ready", i_req_ready, 0);
      check("stall_resp_valid", i_resp_valid, 1);
      check("stall_data", i_resp_data, 32'h1000_0004);
    end
    @(posedge clk); #1 i_resp_ready = 1;
    @(negedge clk); check("release_req_ready", i_req_ready, 1);
    @(posedge clk); #1 i_req_valid = 0;
    repeat (2) @(posedge clk); #1;
    check("stall_count", alog.size() - na, 2);
    check("stall_word", alog[na], 32'h1000_0004);
    check("stall_next", alog[na+1], 32'h1000_0006);
    check("stall_b_data", dlog[nd], 32'h1000_0009);

    // byte-strobed write then read back: bytes 0 and 2 replaced
    nd = dlog.size();
    b_req(0, 1, 32'h20, 4'b0101, 32'hAABB_CCDD);
    b_req(0, 0, 32'h20, 4'h0, 32'h0);
    repeat (2) @(posedge clk); #1;
    check("wr_resp_zero", dlog[nd], 32'h0);
    check("rd_merged", dlog[nd+1], 32'h11BB_33DD);

    // continuous contention alternates d,g,d,g (prime last grant = g)
    ng = glog.size();
    b_req(1, 0, 32'h44, 4'h0, 32'h0);
    n = grnt.size(); nd = dlog.size();
    d_req_valid = 1; d_req_addr = 32'h40; g_req_valid = 1; g_req_addr = 32'h80;
    repeat (4) @(posedge clk); #1;
    d_req_valid = 0; g_req_valid = 0;
    repeat (2) @(posedge clk); #1;
    check("alt_count", grnt.size() - n, 4);
    check("alt_0", grnt[n], 0);
    check("alt_1", grnt[n+1], 1);
    check("alt_2", grnt[n+2], 0);
    check("alt_3", grnt[n+3], 1);
    check("alt_d_data", dlog[nd+1], 32'h1000_0010);
    check("alt_g_prime", glog[ng], 32'h1000_0011);
    check("alt_g_data", glog[ng+2], 32'h1000_0020);

    // same-cycle A read and g write to index 5
    na = alog.size();
    i_req_valid = 1; i_req_addr = 32'h14;
    g_req_valid = 1; g_req_wen = 1; g_req_addr = 32'h14; g_req_strb = 4'hF; g_req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rw_a_ready", i_req_ready, 1);
    check("rw_g_ready", g_req_ready, 1);
    @(posedge clk); #1;
    i_req_valid = 0; g_req_valid = 0; g_req_wen = 0;
    a_fetch(32'h14);
    repeat (2) @(posedge clk); #1;
    check("rw_old", alog[na], 32'h1000_0005);
    check("rw_new", alog[na+1], 32'hCAFE_F00D);

    // reset while g response is stalled
    g_resp_ready = 0;
    b_req(1, 0, 32'h48, 4'h0, 32'h0);
    @(negedge clk); check("pre_rst_g_valid", g_resp_valid, 1);
    @(posedge clk); #1;
    rst_n = 0; d_req_valid = 1; d_req_addr = 32'h4C; i_req_valid = 1; i_req_addr = 32'h0;
    #1;
    check("rst_g_valid_now", g_resp_valid, 0);
    check("rst_d_ready_now", d_req_ready, 0);
    check("rst_i_ready_now", i_req_ready, 0);
    check("rst_rena_now", rena, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1; i_req_valid = 0; g_resp_ready = 1; g_req_valid = 1; g_req_addr = 32'h50;
    n = grnt.size();
    @(negedge clk);
    check("post_rst_d_ready", d_req_ready, 1);
    check("post_rst_g_ready", g_req_ready, 0);
    @(posedge clk); #1 d_req_valid = 0;
    @(posedge clk); #1 g_req_valid = 0;
    repeat (2) @(posedge clk); #1;
    check("post_rst_first", grnt[n], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
